// File: rtl/ufm_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ufm_rom_loader
//  Purpose  : Boot-time copier from the UFM flash (Avalon-MM data port) into
//             the ROM-image RAM. Reads 32-bit words, unpacks each into four
//             little-endian bytes and writes them one per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module ufm_rom_loader #(
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned WORD_COUNT = 4096,
   parameter int unsigned RAM_AW     = 14,
   parameter bit          AUTO_START = 1'b1,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic [12:0]       avmm_data_addr,
   output logic              avmm_data_read,
   output logic [1:0]        avmm_data_burstcount,
   output logic              avmm_data_write,
   output logic [31:0]       avmm_data_writedata,
   input  logic [31:0]       avmm_data_readdata,
   input  logic              avmm_data_waitrequest,
   input  logic              avmm_data_readdatavalid,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_data,
   output logic              ram_we,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int          TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [12:0] BASE_ADDR = 13'(START_ADDR);
   localparam logic [12:0] LAST_WORD = 13'(WORD_COUNT - 1);
   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_UNPACK = 3'd3,
      S_FIN    = 3'd4
   } state_t;

   state_t            state_q, state_nx;
   logic [12:0]       word_idx_q, word_idx_nx;
   logic [1:0]        byte_idx_q, byte_idx_nx;
   logic [TW-1:0]     wait_cnt_q, wait_cnt_nx;
   logic [31:0]       word_q, word_nx;
   logic              done_q, done_nx;
   logic              error_q, error_nx;
   logic              auto_pend_q, auto_pend_nx;
   logic [RAM_AW-1:0] ram_addr_q, ram_addr_nx;
   logic [7:0]        ram_data_q, ram_data_nx;

   logic [RAM_AW-1:0] cur_ram_addr;
   logic [7:0]        cur_byte;

   // Byte currently being unpacked and its RAM destination (4*word + byte).
   assign cur_ram_addr = RAM_AW'({word_idx_q, byte_idx_q});
   assign cur_byte     = word_q[{byte_idx_q, 3'b000} +: 8];

   // Write-only fields of the Avalon port are never used by a pure reader.
   assign avmm_data_burstcount = 2'd1;
   assign avmm_data_write      = 1'b0;
   assign avmm_data_writedata  = 32'd0;

   assign avmm_data_read = (state_q == S_REQ);
   assign avmm_data_addr = (state_q == S_REQ) ? (BASE_ADDR + word_idx_q) : 13'd0;

   // RAM port shows the live byte while unpacking and holds the last one otherwise.
   assign ram_we   = (state_q == S_UNPACK);
   assign ram_addr = ram_we ? cur_ram_addr : ram_addr_q;
   assign ram_data = ram_we ? cur_byte : ram_data_q;

   assign busy  = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_UNPACK);
   assign done  = done_q;
   assign error = error_q;

   // State register and datapath registers; reset abandons any copy in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         word_idx_q  <= '0;
         byte_idx_q  <= '0;
         wait_cnt_q  <= '0;
         word_q      <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         auto_pend_q <= AUTO_START;
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
      end else begin
         state_q     <= state_nx;
         word_idx_q  <= word_idx_nx;
         byte_idx_q  <= byte_idx_nx;
         wait_cnt_q  <= wait_cnt_nx;
         word_q      <= word_nx;
         done_q      <= done_nx;
         error_q     <= error_nx;
         auto_pend_q <= auto_pend_nx;
         ram_addr_q  <= ram_addr_nx;
         ram_data_q  <= ram_data_nx;
      end
   end

   // Next-state logic: request, wait for data (with timeout), unpack four bytes.
   always_comb begin
      state_nx     = state_q;
      word_idx_nx  = word_idx_q;
      byte_idx_nx  = byte_idx_q;
      wait_cnt_nx  = wait_cnt_q;
      word_nx      = word_q;
      done_nx      = done_q;
      error_nx     = error_q;
      auto_pend_nx = auto_pend_q;
      ram_addr_nx  = ram_addr_q;
      ram_data_nx  = ram_data_q;

      case (state_q)
         S_IDLE: begin
            // A pending auto-start behaves exactly like a start pulse.
            if (start || auto_pend_q) begin
               state_nx     = S_REQ;
               done_nx      = 1'b0;
               error_nx     = 1'b0;
               word_idx_nx  = '0;
               auto_pend_nx = 1'b0;
            end
         end
         S_REQ: begin
            if (!avmm_data_waitrequest) begin
               state_nx    = S_WAIT;
               wait_cnt_nx = '0;
            end
         end
         S_WAIT: begin
            if (avmm_data_readdatavalid) begin
               word_nx     = avmm_data_readdata;
               byte_idx_nx = 2'd0;
               state_nx    = S_UNPACK;
            end else if (wait_cnt_q == CNT_LAST) begin
               error_nx = 1'b1;
               state_nx = S_IDLE;
            end else begin
               wait_cnt_nx = wait_cnt_q + 1'b1;
            end
         end
         S_UNPACK: begin
            ram_addr_nx = cur_ram_addr;
            ram_data_nx = cur_byte;
            byte_idx_nx = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
               if (word_idx_q == LAST_WORD) begin
                  state_nx = S_FIN;
                  done_nx  = 1'b1;
               end else begin
                  word_idx_nx = word_idx_q + 13'd1;
                  state_nx    = S_REQ;
               end
            end
         end
         S_FIN: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ufm_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ufm_rom_loader
//  Purpose  : Self-checking bench for ufm_rom_loader with a latency-2 flash
//             model. Instance A uses default parameters, instance B exercises
//             flash address wrap with manual start.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ufm_rom_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;
   int phase  = 0;

   // Flash content: bytes derived from the low address byte.
   function automatic logic [31:0] fdata(input logic [12:0] a);
      logic [7:0] l;
      l = a[7:0];
      return {l + 8'h44, l + 8'h33, l + 8'h22, l + 8'h11};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- instance A: default parameters ----------------
   logic        rst_a, start_a;
   logic [12:0] addr_a;
   logic        read_a, wr_en_a, wreq_a, rdv_a;
   logic [1:0]  bc_a;
   logic [31:0] wdata_a, rdata_a;
   logic [13:0] ram_addr_a;
   logic [7:0]  ram_data_a;
   logic        ram_we_a, busy_a, done_a, error_a;

   ufm_rom_loader dut_a (
      .clock(clk), .reset(rst_a), .start(start_a),
      .avmm_data_addr(addr_a), .avmm_data_read(read_a),
      .avmm_data_burstcount(bc_a), .avmm_data_write(wr_en_a),
      .avmm_data_writedata(wdata_a), .avmm_data_readdata(rdata_a),
      .avmm_data_waitrequest(wreq_a), .avmm_data_readdatavalid(rdv_a),
      .ram_addr(ram_addr_a), .ram_data(ram_data_a), .ram_we(ram_we_a),
      .busy(busy_a), .done(done_a), .error(error_a)
   );

   // Flash model A: waitrequest burst of 5 cycles on word 7, optional drop of word 3.
   int          stall_left = 5;
   logic        stall_on   = 1'b0;
   logic        p1v_a      = 1'b0;
   logic [12:0] p1a_a      = '0;
   logic        rdvq_a     = 1'b0;
   logic [31:0] rdq_a      = '0;
   logic        drop_a;
   logic        force_rdv;

   assign wreq_a  = (stall_left != 0) && (stall_on || (read_a && addr_a == 13'd7));
   assign rdv_a   = rdvq_a | force_rdv;
   assign rdata_a = rdq_a;

   always @(posedge clk) begin
      if (wreq_a) begin
         stall_left <= stall_left - 1;
         stall_on   <= 1'b1;
      end else begin
         stall_on <= 1'b0;
      end
      p1v_a  <= read_a && !wreq_a;
      p1a_a  <= addr_a;
      rdvq_a <= p1v_a && !(drop_a && p1a_a == 13'd3);
      rdq_a  <= fdata(p1a_a);
   end

   // Monitor A: shadow RAM and request bookkeeping, cleared on each phase change.
   logic [8:0] shadow_a [0:16383];
   int mon_phase = -1;
   int nwe_a, nacc_a, max_we_a, first_acc_a, acc7, n_stall, stall_bad;
   int t2_a, t3_a, t_acc3;

   always @(negedge clk) begin
      if (phase != mon_phase) begin
         mon_phase   = phase;
         nwe_a       = 0;
         nacc_a      = 0;
         max_we_a    = -1;
         first_acc_a = -1;
         for (int i = 0; i < 16384; i++) shadow_a[i] = 9'd0;
      end
      if (ram_we_a) begin
         shadow_a[ram_addr_a] = {1'b1, ram_data_a};
         nwe_a++;
         if (int'(ram_addr_a) > max_we_a) max_we_a = int'(ram_addr_a);
         if (ram_addr_a == 14'd8)  t2_a = cyc;
         if (ram_addr_a == 14'd12) t3_a = cyc;
      end
      if (wreq_a) begin
         n_stall++;
         if (!(read_a && addr_a == 13'd7)) stall_bad++;
      end
      if (read_a && !wreq_a) begin
         nacc_a++;
         if (first_acc_a < 0) first_acc_a = int'(addr_a);
         if (addr_a == 13'd7) acc7++;
         if (addr_a == 13'd3) t_acc3 = cyc;
      end
   end

   // ---------------- instance B: wrap-around, manual start ----------------
   logic        rst_b, start_b;
   logic [12:0] addr_b;
   logic        read_b, wr_en_b, rdv_b;
   logic [1:0]  bc_b;
   logic [31:0] wdata_b;
   logic [3:0]  ram_addr_b;
   logic [7:0]  ram_data_b;
   logic        ram_we_b, busy_b, done_b, error_b;
   logic        p1v_b = 1'b0;
   logic [12:0] p1a_b = '0;
   logic        rdvq_b = 1'b0;
   logic [31:0] rdq_b = '0;

   ufm_rom_loader #(
      .START_ADDR(8190), .WORD_COUNT(4), .RAM_AW(4), .AUTO_START(1'b0), .TIMEOUT(1023)
   ) dut_b (
      .clock(clk), .reset(rst_b), .start(start_b),
      .avmm_data_addr(addr_b), .avmm_data_read(read_b),
      .avmm_data_burstcount(bc_b), .avmm_data_write(wr_en_b),
      .avmm_data_writedata(wdata_b), .avmm_data_readdata(rdq_b),
      .avmm_data_waitrequest(1'b0), .avmm_data_readdatavalid(rdv_b),
      .ram_addr(ram_addr_b), .ram_data(ram_data_b), .ram_we(ram_we_b),
      .busy(busy_b), .done(done_b), .error(error_b)
   );

   assign rdv_b = rdvq_b;

   // Flash model B: plain latency-2 reads.
   always @(posedge clk) begin
      p1v_b  <= read_b;
      p1a_b  <= addr_b;
      rdvq_b <= p1v_b;
      rdq_b  <= fdata(p1a_b);
   end

   // Monitor B: accepted addresses, write order and shadow RAM.
   logic [8:0] shadow_b [0:15];
   int acc_b [$];
   int nwe_b = 0, order_bad = 0;
   initial for (int i = 0; i < 16; i++) shadow_b[i] = 9'd0;

   always @(negedge clk) begin
      if (ram_we_b) begin
         if (int'(ram_addr_b) != nwe_b) order_bad++;
         shadow_b[ram_addr_b] = {1'b1, ram_data_b};
         nwe_b++;
      end
      if (read_b) acc_b.push_back(int'(addr_b));
   end

   // ---------------- vector table ----------------
   typedef struct {
      string name;
      int    kind;   // 0: RAM A byte, 1: RAM B byte, 2: B accepted flash address
      int    idx;
      int    exp;
   } vec_t;
   vec_t vt [$];

   task automatic run_table(input int kind);
      foreach (vt[k]) begin
         if (vt[k].kind == kind) begin
            if (kind == 0)
               chk(vt[k].name, shadow_a[vt[k].idx], {1'b1, 8'(vt[k].exp)});
            else if (kind == 1)
               chk(vt[k].name, shadow_b[vt[k].idx], {1'b1, 8'(vt[k].exp)});
            else
               chk(vt[k].name, (vt[k].idx < acc_b.size()) ? acc_b[vt[k].idx] : -1, vt[k].exp);
         end
      end
   endtask

   // ---------------- main sequence ----------------
   int bad, cyc_err;
   logic [31:0] w;

   initial begin
      vt.push_back('{"ramA[0]", 0, 0, 'h11});     vt.push_back('{"ramA[1]", 0, 1, 'h22});
      vt.push_back('{"ramA[2]", 0, 2, 'h33});     vt.push_back('{"ramA[3]", 0, 3, 'h44});
      vt.push_back('{"ramA[4]", 0, 4, 'h12});     vt.push_back('{"ramA[7]", 0, 7, 'h45});
      vt.push_back('{"ramA[28]", 0, 28, 'h18});   vt.push_back('{"ramA[31]", 0, 31, 'h4B});
      vt.push_back('{"ramA[16383]", 0, 16383, 'h43});
      vt.push_back('{"ramB[0]", 1, 0, 'h0F});     vt.push_back('{"ramB[1]", 1, 1, 'h20});
      vt.push_back('{"ramB[2]", 1, 2, 'h31});     vt.push_back('{"ramB[3]", 1, 3, 'h42});
      vt.push_back('{"ramB[4]", 1, 4, 'h10});     vt.push_back('{"ramB[7]", 1, 7, 'h43});
      vt.push_back('{"ramB[8]", 1, 8, 'h11});     vt.push_back('{"ramB[11]", 1, 11, 'h44});
      vt.push_back('{"ramB[12]", 1, 12, 'h12});   vt.push_back('{"ramB[15]", 1, 15, 'h45});
      vt.push_back('{"accB[0]", 2, 0, 8190});     vt.push_back('{"accB[1]", 2, 1, 8191});
      vt.push_back('{"accB[2]", 2, 2, 0});        vt.push_back('{"accB[3]", 2, 3, 1});

      rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      force_rdv = 1'b0; drop_a = 1'b0; phase = 1;
      repeat (3) @(negedge clk);
      chk("reset_outputs_a", {busy_a, done_a, error_a, ram_we_a, read_a, ram_addr_a, ram_data_a, addr_a}, 64'd0);
      chk("const_ports", {bc_a, wr_en_a, wdata_a}, {2'd1, 1'b0, 32'd0});
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      chk("auto_start_req", {busy_a, read_a, addr_a}, {1'b1, 1'b1, 13'd0});

      // Full copy with a 5-cycle stall on word 7.
      for (int k = 0; k < 40000 && !done_a; k++) @(negedge clk);
      chk("copy_done_a", {done_a, busy_a, error_a}, {1'b1, 1'b0, 1'b0});
      chk("bytes_written_a", nwe_a, 16384);
      chk("reads_accepted_a", nacc_a, 4096);
      chk("word7_accepts", acc7, 1);
      chk("stall_cycles", n_stall, 5);
      chk("stall_held_stable", stall_bad, 0);
      chk("cycles_per_word", t3_a - t2_a, 7);
      run_table(0);
      bad = 0;
      for (int i = 0; i < 16384; i++) begin
         w = fdata(13'(i >> 2));
         if (shadow_a[i] !== {1'b1, w[8*(i%4) +: 8]}) bad++;
      end
      chk("ram_a_all_bytes", bad, 0);
      repeat (5) @(negedge clk);
      chk("idle_after_done", {done_a, busy_a, 32'(nacc_a)}, {1'b1, 1'b0, 32'd4096});
      chk("no_auto_b", {busy_b, 32'(acc_b.size())}, 0);

      // Timeout on word 3.
      phase = 3;
      repeat (2) @(negedge clk);
      drop_a = 1'b1; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("start_clears_done", {done_a, busy_a}, {1'b0, 1'b1});
      cyc_err = -1;
      for (int k = 0; k < 3000 && !error_a; k++) @(negedge clk);
      cyc_err = cyc;
      chk("timeout_status", {error_a, done_a, busy_a}, {1'b1, 1'b0, 1'b0});
      chk("timeout_length", cyc_err - t_acc3, 1024);
      chk("timeout_bytes", nwe_a, 12);
      chk("timeout_max_addr", max_we_a, 11);

      // Reset during UNPACK of word 100, then auto restart.
      drop_a = 1'b0; phase = 4;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("start_clears_error", {error_a, busy_a}, {1'b0, 1'b1});
      for (int k = 0; k < 2000 && !(ram_we_a && ram_addr_a == 14'd400); k++) @(negedge clk);
      chk("reached_word100", {ram_we_a, ram_addr_a}, {1'b1, 14'd400});
      rst_a = 1'b1;
      @(negedge clk);
      chk("midcopy_reset_outputs", {busy_a, done_a, error_a, ram_we_a, read_a, ram_addr_a, ram_data_a, addr_a}, 64'd0);
      rst_a = 1'b0; force_rdv = 1'b1; phase = 5;
      @(negedge clk);
      force_rdv = 1'b0;
      chk("restart_req_stale_ignored", {read_a, addr_a, ram_we_a, busy_a}, {1'b1, 13'd0, 1'b0, 1'b1});
      for (int k = 0; k < 100 && nwe_a < 8; k++) @(negedge clk);
      chk("restart_first_acc", first_acc_a, 0);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         w = fdata(13'(i >> 2));
         if (shadow_a[i] !== {1'b1, w[8*(i%4) +: 8]}) bad++;
      end
      chk("restart_bytes", {32'(nwe_a), 32'(bad)}, {32'd8, 32'd0});

      // Instance B: flash address wrap and start-while-busy.
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      chk("b_busy_after_start", busy_b, 1);
      repeat (10) @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      chk("b_busy_ignores_start", busy_b, 1);
      for (int k = 0; k < 200 && !done_b; k++) @(negedge clk);
      chk("b_done", {done_b, busy_b, error_b}, {1'b1, 1'b0, 1'b0});
      run_table(1);
      run_table(2);
      chk("b_write_order", {32'(nwe_b), 32'(order_bad)}, {32'd16, 32'd0});
      repeat (20) @(negedge clk);
      chk("b_no_rerun", {done_b, busy_b, 32'(acc_b.size())}, {1'b1, 1'b0, 32'd4});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
